// File: rtl/cnn_ram_loader.sv
// Turns HPS bus words into RAM port-A writes: one 32-bit word per image-bank write,
// or four LSB-first byte writes into the conv/dense weight RAMs.
module cnn_ram_loader #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned IMG_AW     = 10,
  parameter int unsigned W_AW       = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       writedata,
  input  logic              ctrl_we,
  input  logic              data_we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              wren0,
  output logic              wren1,
  output logic              wren2,
  output logic              wren3,
  output logic [7:0]        data0,
  output logic [7:0]        data1,
  output logic [7:0]        data2,
  output logic [7:0]        data3,
  output logic [IMG_AW-1:0] image_ram_addr,
  output logic              wren_conv,
  output logic              wren_dense,
  output logic [7:0]        data_conv,
  output logic [7:0]        data_dense,
  output logic [W_AW-1:0]   conv_ram_addr,
  output logic [W_AW-1:0]   dense_ram_addr
);

  localparam int unsigned FAW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW    = FAW + 1;
  localparam int unsigned LEN_W = 14;

  localparam logic [1:0] TGT_IMG  = 2'd0;
  localparam logic [1:0] TGT_CONV = 2'd1;
  localparam logic [1:0] TGT_NONE = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_IMG, S_SER} state_e;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        target_q, target_d;
  logic [W_AW-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  credit_q, credit_d;
  logic [FAW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [FAW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              wren_img_q, wren_img_d;
  logic [31:0]       img_data_q, img_data_d;
  logic [IMG_AW-1:0] img_addr_q, img_addr_d;
  logic              wren_conv_q, wren_conv_d;
  logic [7:0]        data_conv_q, data_conv_d;
  logic [W_AW-1:0]   conv_addr_q, conv_addr_d;
  logic              wren_dense_q, wren_dense_d;
  logic [7:0]        data_dense_q, data_dense_d;
  logic [W_AW-1:0]   dense_addr_q, dense_addr_d;

  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [31:0]       head_c;
  logic              ctrl_acc_c;
  logic              push_c;
  logic              pop_c;
  logic              emit_c;
  logic              word_done_c;
  logic [1:0]        sel_c;
  logic [7:0]        byte_c;

  assign head_c = mem_q[rd_ptr_q];

  // Word buffer; the head stays resident until its last write so depth bounds in-flight words.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= writedata;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    target_d     = target_q;
    ptr_d        = ptr_q;
    len_d        = len_q;
    rem_d        = rem_q;
    credit_d     = credit_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    err_d        = err_q;
    wren_img_d   = 1'b0;
    img_data_d   = img_data_q;
    img_addr_d   = img_addr_q;
    wren_conv_d  = 1'b0;
    data_conv_d  = data_conv_q;
    conv_addr_d  = conv_addr_q;
    wren_dense_d = 1'b0;
    data_dense_d = data_dense_q;
    dense_addr_d = dense_addr_q;
    ctrl_acc_c   = ctrl_we && !busy_q;
    push_c       = 1'b0;
    pop_c        = 1'b0;
    emit_c       = 1'b0;
    word_done_c  = 1'b0;
    sel_c        = 2'd0;
    byte_c       = 8'd0;

    if (ctrl_we) begin
      if (busy_q) begin
        err_d = 1'b1;
      end else begin
        target_d = writedata[1:0];
        ptr_d    = W_AW'(writedata[16:2]);
        len_d    = writedata[30:17];
        rem_d    = writedata[30:17];
        credit_d = writedata[30:17];
        err_d    = 1'b0;
      end
    end

    // Credit counts accepted words so words beyond the programmed length never enter the buffer.
    if (data_we) begin
      if (ctrl_we) begin
        err_d = 1'b1;
      end else if (target_q != TGT_NONE) begin
        if ((len_q != '0) && (credit_q == '0)) begin
          err_d = 1'b1;
        end else if (cnt_q == CW'(FIFO_DEPTH)) begin
          err_d = 1'b1;
        end else begin
          push_c = 1'b1;
          if (len_q != '0) credit_d = credit_q - LEN_W'(1);
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          if (target_q == TGT_IMG) begin
            state_d    = S_IMG;
            wren_img_d = 1'b1;
            img_data_d = head_c;
            img_addr_d = ptr_q[IMG_AW-1:0];
          end else if (target_q != TGT_NONE) begin
            state_d = S_SER;
            idx_d   = 2'd0;
            emit_c  = 1'b1;
            sel_c   = 2'd0;
          end else begin
            pop_c = 1'b1;
          end
        end
      end
      S_IMG: begin
        state_d     = S_IDLE;
        pop_c       = 1'b1;
        word_done_c = 1'b1;
        ptr_d       = W_AW'(ptr_q[IMG_AW-1:0] + IMG_AW'(1));
      end
      S_SER: begin
        if (idx_q == 2'd3) begin
          state_d     = S_IDLE;
          pop_c       = 1'b1;
          word_done_c = 1'b1;
        end else begin
          idx_d  = idx_q + 2'd1;
          emit_c = 1'b1;
          sel_c  = idx_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (emit_c) begin
      byte_c = head_c[{sel_c, 3'b000} +: 8];
      if (target_q == TGT_CONV) begin
        wren_conv_d = 1'b1;
        data_conv_d = byte_c;
        conv_addr_d = ptr_q;
      end else begin
        wren_dense_d = 1'b1;
        data_dense_d = byte_c;
        dense_addr_d = ptr_q;
      end
      ptr_d = ptr_q + W_AW'(1);
    end

    if (word_done_c && (len_q != '0)) rem_d = rem_q - LEN_W'(1);
    if (push_c) wr_ptr_d = wr_ptr_q + FAW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + FAW'(1);
    cnt_d  = cnt_q + CW'(push_c) - CW'(pop_c);
    done_d = !ctrl_acc_c && (len_q != '0) && (rem_q == '0);
    busy_d = (cnt_d != '0) || (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= 2'd0;
      target_q     <= TGT_NONE;
      ptr_q        <= '0;
      len_q        <= '0;
      rem_q        <= '0;
      credit_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      wren_img_q   <= 1'b0;
      img_data_q   <= '0;
      img_addr_q   <= '0;
      wren_conv_q  <= 1'b0;
      data_conv_q  <= '0;
      conv_addr_q  <= '0;
      wren_dense_q <= 1'b0;
      data_dense_q <= '0;
      dense_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      target_q     <= target_d;
      ptr_q        <= ptr_d;
      len_q        <= len_d;
      rem_q        <= rem_d;
      credit_q     <= credit_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      wren_img_q   <= wren_img_d;
      img_data_q   <= img_data_d;
      img_addr_q   <= img_addr_d;
      wren_conv_q  <= wren_conv_d;
      data_conv_q  <= data_conv_d;
      conv_addr_q  <= conv_addr_d;
      wren_dense_q <= wren_dense_d;
      data_dense_q <= data_dense_d;
      dense_addr_q <= dense_addr_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign wren0          = wren_img_q;
  assign wren1          = wren_img_q;
  assign wren2          = wren_img_q;
  assign wren3          = wren_img_q;
  assign data0          = img_data_q[7:0];
  assign data1          = img_data_q[15:8];
  assign data2          = img_data_q[23:16];
  assign data3          = img_data_q[31:24];
  assign image_ram_addr = img_addr_q;
  assign wren_conv      = wren_conv_q;
  assign data_conv      = data_conv_q;
  assign conv_ram_addr  = conv_addr_q;
  assign wren_dense     = wren_dense_q;
  assign data_dense     = data_dense_q;
  assign dense_ram_addr = dense_addr_q;

endmodule

// File: tb/tb_cnn_ram_loader.sv
// Scoreboard bench for cnn_ram_loader: a word-level model queues expected RAM writes,
// an independent monitor pops them as write pulses appear.
module tb_cnn_ram_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] writedata;
  logic        ctrl_we, data_we;
  logic        busy, done, err;
  logic        wren0, wren1, wren2, wren3;
  logic [7:0]  data0, data1, data2, data3;
  logic [9:0]  image_ram_addr;
  logic        wren_conv, wren_dense;
  logic [7:0]  data_conv, data_dense;
  logic [14:0] conv_ram_addr, dense_ram_addr;

  cnn_ram_loader dut (
    .clk(clk), .reset(reset), .writedata(writedata), .ctrl_we(ctrl_we), .data_we(data_we),
    .busy(busy), .done(done), .err(err),
    .wren0(wren0), .wren1(wren1), .wren2(wren2), .wren3(wren3),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .image_ram_addr(image_ram_addr),
    .wren_conv(wren_conv), .wren_dense(wren_dense),
    .data_conv(data_conv), .data_dense(data_dense),
    .conv_ram_addr(conv_ram_addr), .dense_ram_addr(dense_ram_addr)
  );

  always #10 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: current target, next address, programmed length, words accepted.
  int   m_tgt = 3;
  int   m_ptr = 0;
  int   m_len = 0;
  int   m_acc = 0;
  bit   m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    m_tgt = 3; m_ptr = 0; m_len = 0; m_acc = 0; m_err = 1'b0;
  endfunction

  function automatic void model_ctrl(input int tgt, input int base, input int len);
    m_tgt = tgt; m_ptr = base; m_len = len; m_acc = 0; m_err = 1'b0;
  endfunction

  function automatic void model_data(input logic [31:0] w, input bit buf_full);
    exp_t e;
    if (m_tgt == 3) return;
    if ((m_len != 0 && m_acc == m_len) || buf_full) begin
      m_err = 1'b1;
      return;
    end
    m_acc++;
    if (m_tgt == 0) begin
      e.kind = 0; e.addr = 32'(m_ptr % 1024); e.data = w;
      exp_q.push_back(e);
      m_ptr = (m_ptr + 1) % 1024;
    end else begin
      for (int i = 0; i < 4; i++) begin
        e.kind = m_tgt; e.addr = 32'(m_ptr); e.data = (w >> (8 * i)) & 32'hFF;
        exp_q.push_back(e);
        m_ptr = (m_ptr + 1) % 32768;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ctrl(input int tgt, input int base, input int len);
    model_ctrl(tgt, base, len);
    writedata = {1'b0, 14'(len), 15'(base), 2'(tgt)};
    ctrl_we   = 1'b1;
    tick();
    ctrl_we   = 1'b0;
  endtask

  task automatic send_data(input logic [31:0] w, input bit buf_full);
    model_data(w, buf_full);
    writedata = w;
    data_we   = 1'b1;
    tick();
    data_we   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
    tick();
  endtask

  task automatic check_status(input string tag);
    check({tag, "_err"}, 32'(err), 32'(m_err));
    check({tag, "_done"}, 32'(done), 32'(m_len != 0 && m_acc == m_len));
  endtask

  task automatic mon_pop(input int kind, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_write: kind %0d addr %h data %h, expected no write", kind, addr, data);
    end else begin
      e = exp_q.pop_front();
      check("write_kind", 32'(kind), 32'(e.kind));
      check("write_addr", addr, e.addr);
      check("write_data", data, e.data);
    end
  endtask

  // Monitor: every write pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if ((wren0 | wren1 | wren2 | wren3) && !(wren0 & wren1 & wren2 & wren3))
        check("img_wren_split", {28'd0, wren3, wren2, wren1, wren0}, 32'hF);
      if (wren0) mon_pop(0, {22'd0, image_ram_addr}, {data3, data2, data1, data0});
      if (wren_conv) mon_pop(1, {17'd0, conv_ram_addr}, {24'd0, data_conv});
      if (wren_dense) mon_pop(2, {17'd0, dense_ram_addr}, {24'd0, data_dense});
    end
  end

  initial begin
    #(20 * 100000);
    $display("FAIL watchdog: run did not complete, expected completion");
    $fatal(1);
  end

  initial begin
    int tgt, base, len, n;
    reset = 1'b1; writedata = '0; ctrl_we = 1'b0; data_we = 1'b0;
    repeat (3) tick();
    check("rst_wren", {26'd0, wren0, wren1, wren2, wren3, wren_conv, wren_dense}, 32'd0);
    check("rst_flags", {29'd0, busy, done, err}, 32'd0);
    check("rst_addr", {conv_ram_addr, dense_ram_addr, 2'b00} | {22'd0, image_ram_addr}, 32'd0);
    check("rst_data", {data0, data1, data2, data3} | {16'd0, data_conv, data_dense}, 32'd0);
    reset = 1'b0;
    tick();

    // Image load with latency and done timing.
    send_ctrl(0, 0, 1);
    send_data(32'hDDCC_BBAA, 1'b0);
    @(negedge clk); check("img_lat_n1", 32'(wren0), 32'd0);
    @(negedge clk); check("img_lat_n2", 32'(wren0), 32'd1);
    @(negedge clk); check("img_done_p1", 32'(done), 32'd0);
    @(negedge clk); check("img_done_p2", 32'(done), 32'd1);
    tick();
    check_status("img");

    // Conv serialisation across the address wrap.
    wait_idle();
    send_ctrl(1, 'h7FFE, 1);
    send_data(32'h4433_2211, 1'b0);
    wait_idle();
    check_status("conv");

    // Back-to-back dense words: third one finds the buffer full.
    send_ctrl(2, 'h100, 0);
    send_data(32'hA1A2_A3A4, 1'b0);
    send_data(32'hB1B2_B3B4, 1'b0);
    send_data(32'hC1C2_C3C4, 1'b1);
    wait_idle();
    check_status("b2b");

    // Control word during serialisation is rejected; the word still completes.
    send_ctrl(1, 'h20, 0);
    send_data(32'h1234_5678, 1'b0);
    tick();
    writedata = {1'b0, 14'd3, 15'h500, 2'd2};
    ctrl_we   = 1'b1;
    tick();
    ctrl_we   = 1'b0;
    m_err     = 1'b1;
    wait_idle();
    check_status("ctrl_busy");
    send_data(32'h9ABC_DEF0, 1'b0);
    wait_idle();
    check_status("ctrl_busy2");

    // Control and data in the same cycle.
    writedata = {1'b0, 14'd0, 15'd5, 2'd0};
    ctrl_we = 1'b1; data_we = 1'b1;
    tick();
    ctrl_we = 1'b0; data_we = 1'b0;
    model_ctrl(0, 5, 0);
    m_err = 1'b1;
    check("same_cycle_err", 32'(err), 32'd1);
    send_data(32'h8765_4321, 1'b0);
    wait_idle();
    check_status("same_cycle");

    // Length overrun with image pointer wrap.
    send_ctrl(0, 'h3FF, 2);
    send_data(32'h0101_0101, 1'b0);
    send_data(32'h0202_0202, 1'b0);
    send_data(32'h0303_0303, 1'b0);
    wait_idle();
    check_status("overrun");

    // Asynchronous reset while byte 1 is on the bus.
    send_ctrl(1, 'h10, 0);
    send_data(32'hFEED_BEEF, 1'b0);
    void'(exp_q.pop_back()); void'(exp_q.pop_back()); void'(exp_q.pop_back());
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("async_rst_wren", {30'd0, wren_conv, wren0}, 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    model_reset();
    send_data(32'h5555_AAAA, 1'b0);
    repeat (8) tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    check_status("post_rst");
    send_ctrl(2, 'h40, 1);
    send_data(32'h0BAD_F00D, 1'b0);
    wait_idle();
    check_status("post_rst_load");

    // Randomised control/data sequences.
    for (int it = 0; it < 30; it++) begin
      tgt  = int'($urandom_range(0, 3));
      base = int'($urandom_range(0, 32767));
      len  = int'($urandom_range(0, 4));
      n    = int'($urandom_range(0, 6));
      send_ctrl(tgt, base, len);
      for (int k = 0; k < n; k++) begin
        send_data($urandom, 1'b0);
        repeat ($urandom_range(5, 7)) tick();
      end
      wait_idle();
      check_status("rand");
    end

    wait_idle();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_ram_loader.md
Name: cnn_ram_loader

Overview:
- Upstream feeder of the accelerator's on-chip RAMs.
- Takes the 32-bit words the HPS writes over the lightweight bus and turns them into byte writes for:
  - the four image banks (10-bit address),
  - the conv-weight RAM (15-bit address),
  - the dense-weight RAM (15-bit address).
- Sits between the bus register decode in the top level and the RAM write ports (port A).
- Buffers up to two data words and serialises weight words byte-by-byte.

Parameters:
- FIFO_DEPTH, 2, data-word buffer depth; power of two.
- IMG_AW, 10, image bank address width.
- W_AW, 15, conv/dense RAM address width.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- writedata  in  32  bus write data
- ctrl_we  in  1  one-cycle strobe: writedata is a control word
- data_we  in  1  one-cycle strobe: writedata is a data word
- busy  out  1  FIFO non-empty or serialisation in progress
- done  out  1  programmed word count fully written to RAM
- err  out  1  sticky error flag; cleared by an accepted control word
- wren0..wren3  out  1 each  image bank write enables
- data0..data3  out  8 each  image bank write data
- image_ram_addr  out  IMG_AW  image bank write address, shared by all four banks
- wren_conv, wren_dense  out  1 each  weight RAM write enables
- data_conv, data_dense  out  8 each  weight RAM write data
- conv_ram_addr, dense_ram_addr  out  W_AW each  weight RAM write addresses

Behaviour:
- Reset: all outputs are 0; state IDLE; FIFO empty; target = 3 (none); pointers and counters are 0.
- Control word fields:
  - [1:0] target: 0 = image, 1 = conv, 2 = dense, 3 = none.
  - [16:2] base address. Image uses [11:2] only.
  - [30:17] length in data words. 0 means unlimited; done never asserts.
  - [31] reserved.
- Accepted control word:
  - Accepted only when busy = 0.
  - Loads target, write pointer = base, remaining = length.
  - Clears done and err.
- Rejected control word: ctrl_we while busy = 1 sets err and changes nothing else.
- ctrl_we and data_we in the same cycle: control is handled as above; the data word is dropped and err is set.
- data_we with the FIFO full: the word is dropped and err is set.
- data_we with target = 3: the word is dropped; no RAM write and no err.
- Outputs are registered. Write enables are single-cycle pulses.
- State machine:
  - IDLE: if the FIFO is non-empty, pop the head word.
    - Target image → go to IMG.
    - Target conv/dense → go to SER with byte index 0.
  - IMG (1 cycle):
    - wren0..3 = 1; dataN = word[8N+7:8N]; image_ram_addr = pointer.
    - Pointer increments the next cycle, wrapping 1023 → 0.
    - Return to IDLE.
  - SER (4 cycles, byte index 0..3):
    - One wren_conv or wren_dense pulse per cycle, data = byte[idx], LSB first.
    - Address = pointer; pointer increments after every byte and wraps 32767 → 0.
    - After idx 3, return to IDLE.
- Throughput:
  - Image: one word per 2 cycles.
  - Weights: one word per 5 cycles.
- Latency: a word accepted at cycle N into an empty FIFO while IDLE produces its first write pulse at N+2.
- Word counting: remaining decrements when a word's last byte is written. When it reaches 0 with a nonzero length:
  - done = 1 from the following cycle;
  - further data words are dropped and set err.
- The RAM address outputs hold the last written address between pulses.
- busy = FIFO non-empty OR state != IDLE.
- Reset mid-operation: everything returns to reset values immediately; partially serialised words are lost.

Test Plan:
- Image load: ctrl 0x0002_0000 (target 0, base 0, len 1), data 0xDDCC_BBAA.
  - Required: one cycle with wren0..3 = 1, data0..3 = AA, BB, CC, DD at addr 0.
  - done = 1 two cycles later; pointer = 1.
- Conv serialise: ctrl target 1, base 0x7FFE, len 1; data 0x4433_2211.
  - Required: wren_conv on 4 consecutive cycles with (addr, data) = (7FFE, 11), (7FFF, 22), (0000, 33), (0001, 44).
  - done = 1 after the last byte.
- Back-to-back: three data_we on consecutive cycles to dense, len 0.
  - Required: first two words written as 8 sequential dense bytes.
  - Third word dropped; err = 1; done stays 0.
- Collisions: ctrl_we during SER → err = 1 and the remaining bytes still complete. ctrl_we and data_we in the same cycle → control applied, data dropped, err = 1.
- Length overrun: len 2 image load with 3 data words.
  - Required: exactly 2 image writes at base and base+1; done = 1; err = 1.
- Async reset asserted during SER byte 1.
  - Required: all wren = 0 and busy = 0 with no clock edge.
  - After release, no further writes until a new control word and data word arrive.
